// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and helpers for the Rx and Tx paths.
//   rx_state_t  - receiver FSM state (IDLE, START, DATA, STOP)
//   tick_div()  - clocks per oversample tick, integer floor
package uart_pkg;

    typedef logic [1:0] rx_state_t;

    localparam rx_state_t IDLE  = 2'd0;
    localparam rx_state_t START = 2'd1;
    localparam rx_state_t DATA  = 2'd2;
    localparam rx_state_t STOP  = 2'd3;

    function automatic int tick_div(input int clk_hz, input int baud, input int os);
        return clk_hz / (baud * os);
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// uart_rx_tick_gen: oversample tick divider with synchronous phase clear.
//   clk  in  system clock
//   rst  in  synchronous reset, active high
//   clr  in  restart the count at 0 (aligns the sampling phase to the start edge)
//   tick out 1-cycle pulse every DIV clocks
module uart_rx_tick_gen #(
    parameter int DIV = 54
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int W = $clog2(DIV + 1);

    logic [W-1:0] cnt;

    assign tick = cnt == W'(DIV - 1);

    always_ff @(posedge clk)
        cnt <= (rst || clr || tick) ? '0 : cnt + 1'b1;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling 8N1 UART receiver, LSB first.
//   clk        in   system clock
//   rst        in   synchronous reset, active high
//   rx         in   serial line, asynchronous, idle high
//   rx_data    out  last correctly received byte
//   rx_valid   out  1-cycle pulse, rx_data just updated
//   frame_err  out  1-cycle pulse, stop bit sampled low
//   busy       out  frame in progress
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TICK_DIV = tick_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int SW       = $clog2(OVERSAMPLE);
    localparam int BW       = $clog2(DATA_BITS + 1);

    logic                 rx_m, rx_s, rx_d;
    rx_state_t            state;
    logic [SW-1:0]        s_cnt;
    logic [BW-1:0]        b_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 tick, start_edge, s_mid, s_last, b_last;

    // Only a fresh falling edge starts a frame, so a line stuck low never re-triggers.
    assign start_edge = state == IDLE && rx_d && !rx_s;
    assign s_mid      = s_cnt == SW'(OVERSAMPLE / 2 - 1);
    assign s_last     = s_cnt == SW'(OVERSAMPLE - 1);
    assign b_last     = b_cnt == BW'(DATA_BITS - 1);
    assign busy       = state != IDLE;

    uart_rx_tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_edge),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            rx_d      <= 1'b1;
            state     <= IDLE;
            s_cnt     <= '0;
            b_cnt     <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_m      <= rx;
            rx_s      <= rx_m;
            rx_d      <= rx_s;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: if (start_edge) begin
                    state <= START;
                    s_cnt <= '0;
                end
                // Mid start bit: a high line here means the edge was a glitch.
                START: if (tick) begin
                    if (s_mid) begin
                        state <= rx_s ? IDLE : DATA;
                        s_cnt <= '0;
                        b_cnt <= '0;
                    end else begin
                        s_cnt <= s_cnt + 1'b1;
                    end
                end
                DATA: if (tick) begin
                    if (s_last) begin
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        s_cnt <= '0;
                        b_cnt <= b_last ? '0 : b_cnt + 1'b1;
                        state <= b_last ? STOP : DATA;
                    end else begin
                        s_cnt <= s_cnt + 1'b1;
                    end
                end
                // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
                STOP: if (tick) begin
                    if (s_last) begin
                        state     <= IDLE;
                        s_cnt     <= '0;
                        rx_valid  <= rx_s;
                        frame_err <= !rx_s;
                        rx_data   <= rx_s ? shreg : rx_data;
                    end else begin
                        s_cnt <= s_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
